// File: rtl/parking_access_arbiter.sv
// rtl/parking_access_arbiter.sv - round-robin arbiter sharing one register manager among parking gates
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   gate_req[NUM_GATES]          per-gate request level, held by the gate until done
//   gate_confirm[NUM_GATES]      per-gate confirm level
//   gate_token[3*NUM_GATES]      per-gate 3-bit user token, gate i on bits [3i+2:3i]
//   car_exit                     one-cycle pulse, a car left the lot
//   mgr_reg_p, mgr_reg_q         classification results from the register manager
//   mgr_request                  session active towards the manager
//   mgr_confirm, mgr_user_token  owner's confirm/token forwarded to the manager
//   grant[NUM_GATES]             one-hot current owner
//   done[NUM_GATES]              one-cycle completion pulse to the owner
//   result_p/q/reject            session outcome, valid while done is nonzero
//   occupancy, full              cars in the lot, occupancy == CAPACITY
module parking_access_arbiter #(
    parameter int NUM_GATES = 4,
    parameter int CAPACITY  = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_GATES-1:0]          gate_req,
    input  logic [NUM_GATES-1:0]          gate_confirm,
    input  logic [3*NUM_GATES-1:0]        gate_token,
    input  logic                          car_exit,
    input  logic                          mgr_reg_p,
    input  logic                          mgr_reg_q,
    output logic                          mgr_request,
    output logic                          mgr_confirm,
    output logic [2:0]                    mgr_user_token,
    output logic [NUM_GATES-1:0]          grant,
    output logic [NUM_GATES-1:0]          done,
    output logic                          result_p,
    output logic                          result_q,
    output logic                          result_reject,
    output logic [$clog2(CAPACITY+1)-1:0] occupancy,
    output logic                          full
);

    localparam int IW = $clog2(NUM_GATES);
    localparam int OW = $clog2(CAPACITY+1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] owner_next;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [TW-1:0] timer;
    logic          in_session;
    logic          accept;
    logic          leave;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_GATES) s = s - NUM_GATES;
        return IW'(s);
    endfunction

    // Scan downwards so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_GATES-1; k >= 0; k--) begin
            if (gate_req[wrap_idx(rr_ptr, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_idx(rr_ptr, k);
            end
        end
    end

    assign owner_next  = (owner == IW'(NUM_GATES-1)) ? '0 : owner + 1'b1;
    assign in_session  = (state == GRANT) || (state == WAIT);
    assign mgr_request = in_session;

    // Owner's confirm and token reach the manager without a register stage.
    always_comb begin
        mgr_confirm    = 1'b0;
        mgr_user_token = 3'b000;
        if (in_session) begin
            for (int i = 0; i < NUM_GATES; i++) begin
                if (owner == IW'(i)) begin
                    mgr_confirm    = gate_confirm[i];
                    mgr_user_token = gate_token[3*i +: 3];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            timer         <= '0;
            grant         <= '0;
            done          <= '0;
            result_p      <= 1'b0;
            result_q      <= 1'b0;
            result_reject <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid && !full) begin
                        owner <= pick_idx;
                        grant <= NUM_GATES'(1) << pick_idx;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // An abandoned session leaves silently and loses its turn.
                    if (!gate_req[owner]) begin
                        grant  <= '0;
                        rr_ptr <= owner_next;
                        state  <= IDLE;
                    end else if (mgr_reg_p) begin
                        done     <= grant;
                        result_p <= 1'b1;
                        state    <= DONE;
                    end else if (mgr_reg_q) begin
                        done     <= grant;
                        result_q <= 1'b1;
                        state    <= DONE;
                    end else if (timer == TW'(TIMEOUT-1)) begin
                        done          <= grant;
                        result_reject <= 1'b1;
                        state         <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    // mgr_request is low here, which returns the manager to its start state.
                    done          <= '0;
                    result_p      <= 1'b0;
                    result_q      <= 1'b0;
                    result_reject <= 1'b0;
                    grant         <= '0;
                    rr_ptr        <= owner_next;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign accept = (state == DONE) && (result_p || result_q);
    assign leave  = car_exit && (occupancy != '0);
    assign full   = (occupancy == OW'(CAPACITY));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
        end else if (accept && !leave) begin
            occupancy <= occupancy + 1'b1;
        end else if (leave && !accept) begin
            occupancy <= occupancy - 1'b1;
        end
    end

endmodule

// File: tb/tb_parking_access_arbiter.sv
// tb/tb_parking_access_arbiter.sv - self-checking bench for parking_access_arbiter
module tb_parking_access_arbiter;

    localparam int N   = 4;
    localparam int CAP = 4;
    localparam int TO  = 16;
    localparam int OW  = $clog2(CAP+1);

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   gate_req;
    logic [N-1:0]   gate_confirm;
    logic [3*N-1:0] gate_token;
    logic           car_exit;
    logic           mgr_reg_p;
    logic           mgr_reg_q;
    logic           mgr_request;
    logic           mgr_confirm;
    logic [2:0]     mgr_user_token;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           result_p;
    logic           result_q;
    logic           result_reject;
    logic [OW-1:0]  occupancy;
    logic           full;

    parking_access_arbiter #(.NUM_GATES(N), .CAPACITY(CAP), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .gate_req(gate_req), .gate_confirm(gate_confirm), .gate_token(gate_token),
        .car_exit(car_exit), .mgr_reg_p(mgr_reg_p), .mgr_reg_q(mgr_reg_q),
        .mgr_request(mgr_request), .mgr_confirm(mgr_confirm), .mgr_user_token(mgr_user_token),
        .grant(grant), .done(done),
        .result_p(result_p), .result_q(result_q), .result_reject(result_reject),
        .occupancy(occupancy), .full(full)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    // Model: the lot, the round-robin pointer and the current session.
    // m_age counts cycles since the grant became visible (0 = grant cycle, k = k-th wait cycle).
    int m_occ, m_ptr, m_owner, m_age, m_res;   // m_res: 1 P, 2 Q, 3 reject
    bit m_in_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_occ = 0; m_ptr = 0; m_owner = -1; m_age = 0; m_res = 0; m_in_done = 0;
    endtask

    task automatic model_edge();
        int inc;
        int dec;
        bit found;
        inc = 0;
        dec = (car_exit && m_occ > 0) ? 1 : 0;
        if (m_in_done) begin
            inc = (m_res == 1 || m_res == 2) ? 1 : 0;
            m_ptr = (m_owner + 1) % N;
            m_owner = -1; m_in_done = 0; m_res = 0;
        end else if (m_owner >= 0) begin
            if (m_age == 0) m_age = 1;
            else if (!gate_req[m_owner]) begin
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end
            else if (mgr_reg_p) begin m_res = 1; m_in_done = 1; end
            else if (mgr_reg_q) begin m_res = 2; m_in_done = 1; end
            else if (m_age == TO) begin m_res = 3; m_in_done = 1; end
            else m_age++;
        end else if (m_occ < CAP) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int g;
                g = (m_ptr + k) % N;
                if (!found && gate_req[g]) begin
                    found = 1; m_owner = g; m_age = 0;
                end
            end
        end
        m_occ = m_occ + inc - dec;
    endtask

    task automatic compare_all();
        int e_grant, e_req, e_conf, e_tok;
        e_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
        e_req = 0; e_conf = 0; e_tok = 0;
        if (m_owner >= 0 && !m_in_done) begin
            e_req  = 1;
            e_conf = int'(gate_confirm[m_owner]);
            e_tok  = int'(gate_token[3*m_owner +: 3]);
        end
        chk("grant", int'(grant), e_grant);
        chk("mgr_request", int'(mgr_request), e_req);
        chk("mgr_confirm", int'(mgr_confirm), e_conf);
        chk("mgr_user_token", int'(mgr_user_token), e_tok);
        chk("done", int'(done), m_in_done ? e_grant : 0);
        chk("result_p", int'(result_p), (m_in_done && m_res == 1) ? 1 : 0);
        chk("result_q", int'(result_q), (m_in_done && m_res == 2) ? 1 : 0);
        chk("result_reject", int'(result_reject), (m_in_done && m_res == 3) ? 1 : 0);
        chk("occupancy", int'(occupancy), m_occ);
        chk("full", int'(full), (m_occ == CAP) ? 1 : 0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int order[$];
        logic [N-1:0] prevg;
        int n;
        bit mute;

        reset = 1'b1;
        gate_req = '0; gate_confirm = '0; gate_token = '0;
        car_exit = 1'b0; mgr_reg_p = 1'b0; mgr_reg_q = 1'b0;
        #2;
        model_reset();
        compare_all();
        chk("reset_occupancy", int'(occupancy), 0);
        @(negedge clock);
        reset = 1'b0;

        // Single gate, token 101, Q on the third wait cycle.
        gate_req = 4'b0001; gate_confirm = 4'b0001; gate_token = 12'h005;
        tick();
        chk("single_grant", int'(grant), 1);
        chk("single_token", int'(mgr_user_token), 5);
        chk("single_request", int'(mgr_request), 1);
        tick(); tick(); tick();
        mgr_reg_q = 1'b1;
        tick();
        chk("single_done", int'(done), 1);
        chk("single_result_q", int'(result_q), 1);
        chk("single_request_low", int'(mgr_request), 0);
        mgr_reg_q = 1'b0; gate_req = '0;
        tick();
        chk("single_occupancy", int'(occupancy), 1);

        // Round-robin over gates 0..2, every session accepted with P.
        do_reset();
        gate_req = 4'b0111; mgr_reg_p = 1'b1; prevg = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grant != '0 && prevg == '0) order.push_back(int'(grant));
            prevg = grant;
        end
        chk("rr_sessions", (order.size() >= 4) ? 1 : 0, 1);
        if (order.size() >= 4) begin
            chk("rr_first", order[0], 1);
            chk("rr_second", order[1], 2);
            chk("rr_third", order[2], 4);
            chk("rr_fourth", order[3], 1);
        end
        chk("rr_occupancy", int'(occupancy), 4);
        chk("rr_full", int'(full), 1);

        // Full lot blocks gate 3 until a car leaves.
        gate_req = 4'b1000; mgr_reg_p = 1'b0;
        tick(); tick(); tick();
        chk("full_no_grant", int'(grant), 0);
        car_exit = 1'b1;
        tick();
        car_exit = 1'b0;
        chk("exit_occupancy", int'(occupancy), 3);
        tick();
        chk("full_released_grant", int'(grant), 8);

        // Gate 3 times out with no manager response.
        n = 0;
        while (done == '0 && n < 40) begin tick(); n++; end
        chk("g3_done", int'(done), 8);
        chk("g3_reject", int'(result_reject), 1);
        gate_req = 4'b0010;
        tick();
        chk("g3_occupancy_kept", int'(occupancy), 3);

        // Gate 1 timeout length and pointer advance.
        n = 0;
        while (grant == '0 && n < 10) begin tick(); n++; end
        chk("g1_grant", int'(grant), 2);
        n = 0;
        while (done == '0 && n < 40) begin tick(); n++; end
        chk("timeout_len", n, TO + 1);
        chk("g1_reject", int'(result_reject), 1);
        gate_req = 4'b0101;
        tick(); tick();
        chk("after_g1_grant", int'(grant), 4);

        // Owner drops its request mid-wait.
        tick(); tick();
        gate_req = '0;
        tick();
        chk("drop_grant", int'(grant), 0);
        chk("drop_done", int'(done), 0);

        // Accept in the same cycle as a car exit.
        gate_req = 4'b0001; mgr_reg_p = 1'b1;
        tick(); tick(); tick();
        chk("accexit_done", int'(done), 1);
        car_exit = 1'b1; gate_req = '0; mgr_reg_p = 1'b0;
        tick();
        car_exit = 1'b0;
        chk("accexit_occupancy", int'(occupancy), 3);

        // Car exit at an empty lot.
        do_reset();
        car_exit = 1'b1;
        tick();
        car_exit = 1'b0;
        chk("exit_at_zero", int'(occupancy), 0);

        // Asynchronous reset in the middle of a wait.
        gate_req = 4'b0100;
        tick(); tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("async_request", int'(mgr_request), 0);
        chk("async_grant", int'(grant), 0);
        @(negedge clock);
        reset = 1'b0;
        gate_req = 4'b1111;
        tick();
        chk("post_reset_grant", int'(grant), 1);
        gate_req = '0;

        // Randomized traffic with silent-manager stretches to force timeouts.
        for (int i = 0; i < 3000; i++) begin
            mute = ((i % 400) >= 300);
            for (int g = 0; g < N; g++) begin
                if (!gate_req[g]) gate_req[g] = ($urandom_range(0, 99) < 25);
                else if ($urandom_range(0, 99) < 3) gate_req[g] = 1'b0;
            end
            gate_confirm = N'($urandom);
            gate_token   = (3*N)'($urandom);
            car_exit     = ($urandom_range(0, 99) < 12);
            mgr_reg_p    = !mute && ($urandom_range(0, 99) < 10);
            mgr_reg_q    = !mute && ($urandom_range(0, 99) < 10);
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
